// File: rtl/peri_pdm_multi.sv
// Wishbone-controlled multi-channel first-order sigma-delta PDM with global enable,
// atomic staged level writes and an optional slew-rate-limited ramp toward each target.
module peri_pdm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12,
  parameter int RAMP_DIV = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_adr_i,
  input  logic [7:0]          wb_dat_i,
  input  logic                wb_stb_i,
  output logic [7:0]          wb_dat_o,
  output logic                wb_ack_o,
  output logic [CHANNELS-1:0] pdm_o
);

  localparam int PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int LAST_ADR = 2 * CHANNELS + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);

  logic [1:0]          ctrl_q, ctrl_d;
  logic [7:0]          stage_q, stage_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [WIDTH-1:0]    target_q [CHANNELS];
  logic [WIDTH-1:0]    target_d [CHANNELS];
  logic [WIDTH-1:0]    cur_q    [CHANNELS];
  logic [WIDTH-1:0]    cur_d    [CHANNELS];
  logic [WIDTH:0]      acc_q    [CHANNELS];
  logic [WIDTH:0]      acc_d    [CHANNELS];

  logic                wrEn;
  logic                lvlHit;
  logic                lvlHi;
  logic                en;
  logic                ramp;
  logic                tick;
  logic [2:0]          lvlCh;
  logic [CHANNELS-1:0] ramping;
  logic [15:0]         tgtExt;

  assign wrEn     = wb_stb_i && wb_we_i;
  assign lvlHit   = (wb_adr_i >= 4'd2) && (32'(wb_adr_i) <= 32'(LAST_ADR));
  assign lvlHi    = wb_adr_i[0];
  // Address pairs 2/3, 4/5, ... select channel 0, 1, ...
  assign lvlCh    = wb_adr_i[3:1] - 3'd1;
  assign en       = ctrl_q[0];
  assign ramp     = ctrl_q[1];
  assign tick     = ramp && (presc_q == PRESC_MAX);
  assign wb_ack_o = wb_stb_i;

  always_comb begin
    ctrl_d   = ctrl_q;
    stage_d  = stage_q;
    target_d = target_q;
    if (wrEn) begin
      if (wb_adr_i == 4'd0) begin
        ctrl_d = wb_dat_i[1:0];
      end else if (lvlHit && !lvlHi) begin
        stage_d = wb_dat_i;
      end else if (lvlHit) begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (lvlCh == 3'(n)) begin
            target_d[n] = {wb_dat_i[WIDTH-9:0], stage_q};
          end
        end
      end
    end
  end

  // Ramp steps compare against the registered target, so a write landing in a
  // tick cycle only takes effect on the following tick.
  always_comb begin
    presc_d = '0;
    if (ramp && !tick) begin
      presc_d = presc_q + PW'(1);
    end
    for (int n = 0; n < CHANNELS; n++) begin
      cur_d[n] = cur_q[n];
      if (!ramp) begin
        cur_d[n] = target_q[n];
      end else if (tick && (cur_q[n] < target_q[n])) begin
        cur_d[n] = cur_q[n] + WIDTH'(1);
      end else if (tick && (cur_q[n] > target_q[n])) begin
        cur_d[n] = cur_q[n] - WIDTH'(1);
      end
      acc_d[n] = '0;
      if (en) begin
        acc_d[n] = {1'b0, acc_q[n][WIDTH-1:0]} + {1'b0, cur_q[n]};
      end
      ramping[n] = (cur_q[n] != target_q[n]);
      pdm_o[n]   = acc_q[n][WIDTH];
    end
  end

  always_comb begin
    wb_dat_o = '0;
    tgtExt   = '0;
    if (wb_adr_i == 4'd0) begin
      wb_dat_o = {6'd0, ctrl_q};
    end else if (wb_adr_i == 4'd1) begin
      wb_dat_o = 8'(ramping);
    end else if (lvlHit) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (lvlCh == 3'(n)) begin
          tgtExt = 16'(target_q[n]);
        end
      end
      wb_dat_o = lvlHi ? tgtExt[15:8] : tgtExt[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      stage_q <= '0;
      presc_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        target_q[n] <= '0;
        cur_q[n]    <= '0;
        acc_q[n]    <= '0;
      end
    end else begin
      ctrl_q  <= ctrl_d;
      stage_q <= stage_d;
      presc_q <= presc_d;
      for (int n = 0; n < CHANNELS; n++) begin
        target_q[n] <= target_d[n];
        cur_q[n]    <= cur_d[n];
        acc_q[n]    <= acc_d[n];
      end
    end
  end

endmodule
